clock_phase_gen: RTL and testbench
==================================

Name: clock_phase_gen

Overview:
- Produces the clock-enable strobes that sequence the processor skeleton's imem, regfile, dmem and processor stages from one master clock.
- Produces the held core reset that the skeleton consumes.
- Conditions the raw board/testbench reset.
- Adds run/pause/single-step control so benches and the debug path can advance the core one processor cycle at a time.

Parameters:
HOLD_CYCLES, 4, number of clocks core_reset stays high after the synchronized reset release (legal range 1..255)
CNT_W, 32, width of the completed-processor-cycle counter

Ports:
clock  input  1  master clock; all flops are rising-edge triggered
reset  input  1  asynchronous, active-low reset (0 = in reset)
run  input  1  1 = free-running sequencing; 0 = pause at the next processor-cycle boundary
step  input  1  one-cycle pulse; while paused, requests exactly one processor cycle
core_reset  output  1  active-high reset to the skeleton core, held per Behaviour
imem_ce  output  1  one-clock strobe in phase 0
regfile_ce  output  1  one-clock strobe in phase 1
dmem_ce  output  1  one-clock strobe in phase 2
processor_ce  output  1  one-clock strobe in phase 3
phase  output  2  current phase index; 0 whenever no sequence is active
paused  output  1  1 while in PAUSE
cycle_count  output  CNT_W  number of completed processor cycles; wraps modulo 2^CNT_W

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- reset=0 immediately forces the following values: core_reset=1, all *_ce=0, phase=0, paused=0, cycle_count=0, state=HOLD, hold counter=0.
- Release: reset passes through a 2-flop synchronizer. Assertion is async; deassertion is sync and takes effect on the 2nd rising edge after reset goes high.
- Hold timing: core_reset falls on the (2+HOLD_CYCLES)th rising edge after reset rises. With the default, that is the 6th edge.
- States: HOLD, RUN, PAUSE, STEP.
- HOLD -> RUN if run=1 on the exit edge; otherwise HOLD -> PAUSE.
- RUN: phase advances 0,1,2,3,0,... with one strobe per clock, matching phase. The first strobe (imem_ce) is high in the first cycle that core_reset=0.
- Every processor_ce cycle increments cycle_count on the closing edge.
- RUN, run=0: the current sequence always completes through phase 3. A processor cycle is never truncated. Entry to PAUSE occurs on the edge that closes phase 3.
- PAUSE: all strobes 0, phase=0, paused=1.
  - run=1 -> RUN on the next edge; imem_ce is high in the following cycle.
  - Otherwise, step=1 -> STEP.
  - If run and step are both 1, run wins.
- STEP: exactly one 0..3 sequence. At the phase-3 edge, go to RUN if run=1, else PAUSE. step pulses in STEP, RUN or HOLD are ignored, not queued.
- Exactly one *_ce is high in any cycle outside HOLD/PAUSE. None is high in HOLD/PAUSE.
- Reset asserted mid-sequence: outputs take their reset values immediately (async). A partial sequence is abandoned. cycle_count clears.
- All outputs are registered; there are no combinational paths from run/step to outputs.

Decomposition:
- Shared package clock_phase_pkg:
  - state enum: HOLD, RUN, PAUSE, STEP.
  - phase constants: PH_IMEM=0, PH_REGFILE=1, PH_DMEM=2, PH_PROC=3.
  - default HOLD_CYCLES.
- One sub-module: reset_sync (2-flop, async-assert / sync-deassert, active-low in and out). It is reusable by other blocks in the skeleton.

Test Plan:
- Hold reset=0 for 3 clocks, then release with run=1 -> core_reset=1 through edge 5 and 0 after edge 6. The following 8 cycles show imem, regfile, dmem, processor, imem, ... and cycle_count=2.
- RUN, drop run during phase 1 -> regfile, dmem and processor strobes still fire. paused=1 from the next cycle, cycle_count increments exactly once, and no further strobes appear over 10 clocks.
- PAUSE, issue 3 step pulses spaced 8 clocks apart -> exactly 12 strobes in order, cycle_count +3, and paused returns to 1 after each sequence.
- STEP in progress, pulse step again at phase 2 -> ignored: only 4 strobes total, cycle_count +1.
- RUN, assert reset=0 mid-phase 2 -> dmem_ce, core_reset and cycle_count go to 0/1/0 before the next edge. After release, the full 6-edge hold is repeated.
- Preload cycle_count near its limit (force, CNT_W=32, value 0xFFFFFFFF) and run one cycle -> cycle_count=0. No other output is disturbed.

Source files
------------

// File: rtl/clock_phase_gen_pkg.sv
// +--------------------------------------------------------------------+
// | clock_phase_pkg : shared states, phase indices and strobe helper    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package clock_phase_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_e;

    localparam logic [1:0] PH_IMEM    = 2'd0;
    localparam logic [1:0] PH_REGFILE = 2'd1;
    localparam logic [1:0] PH_DMEM    = 2'd2;
    localparam logic [1:0] PH_PROC    = 2'd3;

    localparam int HOLD_CYCLES_DEF = 4;

    // One-hot strobe vector {processor, dmem, regfile, imem} for a phase.
    function automatic logic [3:0] phase_strobe(input logic [1:0] ph);
        return 4'b0001 << ph;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_phase_gen_reset_sync.sv
// +--------------------------------------------------------------------+
// | reset_sync : 2-flop async-assert / sync-deassert active-low reset   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module reset_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_n_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/clock_phase_gen.sv
// +--------------------------------------------------------------------+
// | clock_phase_gen : 4-phase clock-enable sequencer with held core     |
// | reset and run/pause/single-step control. Revision : 1.0             |
// +--------------------------------------------------------------------+
`default_nettype none

module clock_phase_gen
    import clock_phase_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    output logic             core_reset,
    output logic             imem_ce,
    output logic             regfile_ce,
    output logic             dmem_ce,
    output logic             processor_ce,
    output logic [1:0]       phase,
    output logic             paused,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic             rst_sync_n;
    state_e           state_q;
    logic [7:0]       hold_q;
    logic [7:0]       hold_d;
    logic [1:0]       phase_q;
    logic [1:0]       phase_d;
    logic [3:0]       ce_q;
    logic             paused_q;
    logic             core_reset_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;

    reset_sync u_reset_sync (
        .clk_i   (clock),
        .rst_n_i (reset),
        .rst_n_o (rst_sync_n)
    );

    assign hold_d        = hold_q + 8'd1;
    assign phase_d       = phase_q + 2'd1;
    assign cycle_count_d = cycle_count_q + CNT_W'(1);

    // RUN and STEP share sequencing; they differ only in how they were entered.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q       <= HOLD;
            hold_q        <= 8'd0;
            phase_q       <= PH_IMEM;
            ce_q          <= 4'b0000;
            paused_q      <= 1'b0;
            core_reset_q  <= 1'b1;
            cycle_count_q <= '0;
        end else begin
            if (ce_q[PH_PROC]) begin
                cycle_count_q <= cycle_count_d;
            end
            case (state_q)
                HOLD: begin
                    if (hold_q == c_HOLD_LAST) begin
                        core_reset_q <= 1'b0;
                        if (run) begin
                            state_q <= RUN;
                            ce_q    <= phase_strobe(PH_IMEM);
                        end else begin
                            state_q  <= PAUSE;
                            paused_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                PAUSE: begin
                    if (run || step) begin
                        state_q  <= run ? RUN : STEP;
                        paused_q <= 1'b0;
                        phase_q  <= PH_IMEM;
                        ce_q     <= phase_strobe(PH_IMEM);
                    end
                end
                RUN, STEP: begin
                    if (phase_q == PH_PROC) begin
                        phase_q <= PH_IMEM;
                        if (run) begin
                            state_q <= RUN;
                            ce_q    <= phase_strobe(PH_IMEM);
                        end else begin
                            state_q  <= PAUSE;
                            paused_q <= 1'b1;
                            ce_q     <= 4'b0000;
                        end
                    end else begin
                        phase_q <= phase_d;
                        ce_q    <= phase_strobe(phase_d);
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    assign core_reset   = core_reset_q;
    assign imem_ce      = ce_q[PH_IMEM];
    assign regfile_ce   = ce_q[PH_REGFILE];
    assign dmem_ce      = ce_q[PH_DMEM];
    assign processor_ce = ce_q[PH_PROC];
    assign phase        = phase_q;
    assign paused       = paused_q;
    assign cycle_count  = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_phase_gen.sv
// +--------------------------------------------------------------------+
// | tb_clock_phase_gen : scoreboard bench for clock_phase_gen           |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_clock_phase_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b1;
    logic        step  = 1'b0;
    logic        core_reset;
    logic        imem_ce;
    logic        regfile_ce;
    logic        dmem_ce;
    logic        processor_ce;
    logic [1:0]  phase;
    logic        paused;
    logic [31:0] cycle_count;

    typedef struct {
        logic [3:0]  ce;
        logic [1:0]  ph;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0] mon_ce;
    int checks = 0;
    int errors = 0;

    clock_phase_gen #(
        .HOLD_CYCLES (4),
        .CNT_W       (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .step         (step),
        .core_reset   (core_reset),
        .imem_ce      (imem_ce),
        .regfile_ce   (regfile_ce),
        .dmem_ce      (dmem_ce),
        .processor_ce (processor_ce),
        .phase        (phase),
        .paused       (paused),
        .cycle_count  (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expect one full imem..processor sequence with the given count value.
    task automatic push_seq(input logic [31:0] c);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.ce  = 4'(1 << i);
            e.ph  = 2'(i);
            e.cnt = c;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every strobe cycle must match the head of the expectation queue.
    always @(negedge clock) begin
        mon_ce = {processor_ce, dmem_ce, regfile_ce, imem_ce};
        if (mon_ce != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got ce=%b expected none", mon_ce);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_ce", 32'(mon_ce), 32'(mon_e.ce));
                check("strobe_phase", 32'(phase), 32'(mon_e.ph));
                check("strobe_count", cycle_count, mon_e.cnt);
                check("strobe_paused", 32'(paused), 32'd0);
                check("strobe_core_reset", 32'(core_reset), 32'd0);
            end
        end
    end

    initial begin
        // Power-up reset, then release with run=1.
        tick(3);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_count", cycle_count, 32'd0);
        push_seq(32'd0);
        push_seq(32'd1);
        push_seq(32'd2);
        reset = 1'b1;
        tick(5);
        check("hold_edge5", 32'(core_reset), 32'd1);
        tick(1);
        check("hold_edge6", 32'(core_reset), 32'd0);
        tick(8);
        check("run_count2", cycle_count, 32'd2);

        // Drop run during phase 1: sequence completes, then pause.
        tick(1);
        check("drop_phase1", 32'(phase), 32'd1);
        run = 1'b0;
        tick(3);
        check("pause_entry", 32'(paused), 32'd1);
        check("pause_count", cycle_count, 32'd3);
        tick(10);
        check("pause_hold", 32'(paused), 32'd1);
        check("pause_hold_count", cycle_count, 32'd3);

        // Three single steps, 8 clocks apart.
        push_seq(32'd3);
        push_seq(32'd4);
        push_seq(32'd5);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(7);
            check("step_repause", 32'(paused), 32'd1);
        end
        check("step_count", cycle_count, 32'd6);

        // Second step pulse during an active step is ignored.
        push_seq(32'd6);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
        check("step_at_phase2", 32'(phase), 32'd2);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(6);
        check("step_ignored_paused", 32'(paused), 32'd1);
        check("step_ignored_count", cycle_count, 32'd7);

        // Reset asserted mid-phase 2 of a run.
        exp_q.push_back('{ce: 4'b0001, ph: 2'd0, cnt: 32'd7});
        exp_q.push_back('{ce: 4'b0010, ph: 2'd1, cnt: 32'd7});
        exp_q.push_back('{ce: 4'b0100, ph: 2'd2, cnt: 32'd7});
        run = 1'b1;
        tick(3);
        #2 reset = 1'b0;
        #1;
        check("async_dmem_ce", 32'(dmem_ce), 32'd0);
        check("async_core_reset", 32'(core_reset), 32'd1);
        check("async_count", cycle_count, 32'd0);
        check("async_phase", 32'(phase), 32'd0);
        tick(2);
        push_seq(32'd0);
        reset = 1'b1;
        tick(5);
        check("rehold_edge5", 32'(core_reset), 32'd1);
        tick(1);
        check("rehold_edge6", 32'(core_reset), 32'd0);
        run = 1'b0;
        tick(4);
        check("rehold_paused", 32'(paused), 32'd1);
        check("rehold_count", cycle_count, 32'd1);

        // Counter wrap from all-ones.
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_count_q;
        tick(1);
        check("preload_count", cycle_count, 32'hFFFF_FFFF);
        push_seq(32'hFFFF_FFFF);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(4);
        check("wrap_count", cycle_count, 32'd0);
        check("wrap_paused", 32'(paused), 32'd1);
        check("wrap_core_reset", 32'(core_reset), 32'd0);
        check("wrap_phase", 32'(phase), 32'd0);

        tick(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
